// File: rtl/mr_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter: grant held for the owner's whole CYC,
// outstanding requests counted so responses return to the owner (or are dropped).
//
// state    | meaning
// GNT_NONE | no master owns the slave port, both masters stalled
// GNT_M0   | m0 (ifetch) owns the slave port
// GNT_M1   | m1 (LD-ST) owns the slave port
module mr_wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int MAX_OUT = 4,
  parameter int FAIR    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   m0_adr_i,
  input  logic [XLEN-1:0]   m0_dat_i,
  input  logic              m0_we_i,
  input  logic [XLEN/8-1:0] m0_sel_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  output logic [XLEN-1:0]   m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_stall_o,
  input  logic [XLEN-1:0]   m1_adr_i,
  input  logic [XLEN-1:0]   m1_dat_i,
  input  logic              m1_we_i,
  input  logic [XLEN/8-1:0] m1_sel_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  output logic [XLEN-1:0]   m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_stall_o,
  output logic [XLEN-1:0]   s_adr_o,
  output logic [XLEN-1:0]   s_dat_o,
  output logic              s_we_o,
  output logic [XLEN/8-1:0] s_sel_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  input  logic [XLEN-1:0]   s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_stall_i
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } gnt_t;

  gnt_t          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_cyc, own_stb, at_max, accept, rsp, rsp_live;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q  <= GNT_NONE;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    own_cyc    = 1'b0;
    own_stb    = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_we_o     = 1'b0;
    s_sel_o    = '0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    at_max     = (cnt_q == CNT_MAX);
    // A response only counts against an outstanding request; ack+err is one response.
    rsp        = (s_ack_i | s_err_i) & (cnt_q != '0);

    case (gnt_q)
      GNT_M0: begin
        own_cyc    = m0_cyc_i;
        own_stb    = m0_stb_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        m0_stall_o = s_stall_i | at_max;
        m0_ack_o   = rsp & m0_cyc_i & ~s_err_i;
        m0_err_o   = rsp & m0_cyc_i & s_err_i;
      end
      GNT_M1: begin
        own_cyc    = m1_cyc_i;
        own_stb    = m1_stb_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        m1_stall_o = s_stall_i | at_max;
        m1_ack_o   = rsp & m1_cyc_i & ~s_err_i;
        m1_err_o   = rsp & m1_cyc_i & s_err_i;
      end
      default: ;
    endcase

    s_cyc_o  = own_cyc;
    s_stb_o  = own_stb & own_cyc & ~at_max;
    accept   = s_stb_o & ~s_stall_i;
    rsp_live = rsp & own_cyc;

    if (!own_cyc) begin
      // Owner gone (or none): forget in-flight requests, re-arbitrate this edge.
      cnt_d = '0;
      if (m0_cyc_i && m1_cyc_i)
        gnt_d = (FAIR != 0 && last_q) ? GNT_M0 : GNT_M1;
      else if (m1_cyc_i)
        gnt_d = GNT_M1;
      else if (m0_cyc_i)
        gnt_d = GNT_M0;
      else
        gnt_d = GNT_NONE;
      if (gnt_d != GNT_NONE)
        last_d = (gnt_d == GNT_M1);
    end else if (accept && !rsp_live) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!accept && rsp_live) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

endmodule
